// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//   Stack controller sitting directly in front of a synchronous two-port stack
//   RAM (registered read data on both ports). It owns the stack pointer and
//   turns PUSH / POP / PEEK / POP2 commands into RAM port-A writes and port-A/B
//   reads. Results come back on a registered, non-stallable response strobe.
//   Rejected commands raise sticky overflow / underflow flags.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   clear           synchronous flush of the stack pointer
//   cmd_valid/ready command handshake; cmd_op 00 PUSH 01 POP 10 PEEK 11 POP2
//   cmd_data        PUSH data
//   cmd_off         PEEK depth below top of stack (0 = top)
//   rsp_valid       one-cycle response strobe
//   rsp_err         command rejected
//   rsp_data0/1     response words (data1 only meaningful for POP2)
//   sp              current stack depth 0..DEPTH
//   full, empty     sp==DEPTH, sp==0
//   overflow        sticky: a PUSH was rejected
//   underflow       sticky: a POP/POP2/PEEK was rejected
//   ram_*           RAM port A (read/write) and port B (read-only)
// -----------------------------------------------------------------------------
`ifndef RAM_DEPTH
`define RAM_DEPTH 8
`endif

module stack_ctrl #(
   parameter int DEPTH = `RAM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [31:0]   cmd_data,
   input  logic [AW-1:0] cmd_off,
   output logic          rsp_valid,
   output logic          rsp_err,
   output logic [31:0]   rsp_data0,
   output logic [31:0]   rsp_data1,
   output logic [AW:0]   sp,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   output logic          underflow,
   output logic [31:0]   ram_addr_a,
   output logic [31:0]   ram_datain_a,
   output logic          ram_wr_a,
   output logic [31:0]   ram_addr_b,
   input  logic [31:0]   ram_data_a,
   input  logic [31:0]   ram_data_b
);

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PEEK = 2'b10;
   localparam logic [1:0] OP_POP2 = 2'b11;

   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
   localparam logic [AW:0] SP_TWO  = (AW+1)'(2);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   sp_q, sp_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_data0_q, rsp_data0_d;
   logic [31:0]   rsp_data1_q, rsp_data1_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          pop2_q, pop2_d;   // pending read was a POP2

   logic          accept;
   logic          cmd_err;
   logic          cmd_ok;
   logic [AW:0]   off_ext;
   logic [AW:0]   addr_a;
   logic [AW:0]   addr_b;

   // All error checks use the stack pointer as it stands at accept time.
   always_comb begin
      off_ext = {1'b0, cmd_off};
      cmd_err = 1'b0;
      unique case (cmd_op)
         OP_PUSH: cmd_err = (sp_q == SP_FULL);
         OP_POP:  cmd_err = (sp_q == '0);
         OP_PEEK: cmd_err = (off_ext >= sp_q);
         OP_POP2: cmd_err = (sp_q < SP_TWO);
         default: cmd_err = 1'b0;
      endcase
   end

   assign accept = cmd_valid && cmd_ready;
   assign cmd_ok = accept && !cmd_err;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (cmd_ok && cmd_op != OP_PUSH) state_d = S_WAIT;
         S_WAIT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (handshake + RAM drive) ----------------
   always_comb begin
      cmd_ready    = (state_q == S_IDLE) && !clear;
      ram_wr_a     = 1'b0;
      addr_a       = '0;
      addr_b       = '0;
      ram_datain_a = '0;
      if (cmd_ok) begin
         unique case (cmd_op)
            OP_PUSH: begin
               ram_wr_a     = 1'b1;
               addr_a       = sp_q;
               ram_datain_a = cmd_data;
            end
            OP_POP:  addr_a = sp_q - SP_ONE;
            OP_PEEK: addr_a = sp_q - SP_ONE - off_ext;
            OP_POP2: begin
               addr_a = sp_q - SP_ONE;
               addr_b = sp_q - SP_TWO;
            end
            default: ;
         endcase
      end
   end

   assign ram_addr_a = {{(32-AW-1){1'b0}}, addr_a};
   assign ram_addr_b = {{(32-AW-1){1'b0}}, addr_b};

   // ---------------- datapath next-state ----------------
   always_comb begin
      sp_d        = sp_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_data0_d = rsp_data0_q;
      rsp_data1_d = rsp_data1_q;
      pop2_d      = pop2_q;
      ovf_d       = ovf_q | (accept && cmd_err && cmd_op == OP_PUSH);
      unf_d       = unf_q | (accept && cmd_err && cmd_op != OP_PUSH);

      if (cmd_ok) begin
         pop2_d = (cmd_op == OP_POP2);
         unique case (cmd_op)
            OP_PUSH: sp_d = sp_q + SP_ONE;
            OP_POP:  sp_d = sp_q - SP_ONE;
            OP_POP2: sp_d = sp_q - SP_TWO;
            default: sp_d = sp_q;
         endcase
      end
      // clear wins over any stack-pointer update, including the one just
      // applied at accept time for a read that is still in WAIT.
      if (clear) sp_d = '0;

      if (state_q == S_WAIT) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b0;
         rsp_data0_d = ram_data_a;
         rsp_data1_d = pop2_q ? ram_data_b : 32'h0;
      end else if (accept && cmd_err) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         rsp_data0_d = 32'h0;
         rsp_data1_d = 32'h0;
      end else if (cmd_ok && cmd_op == OP_PUSH) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b0;
         rsp_data0_d = cmd_data;
         rsp_data1_d = 32'h0;
      end
   end

   // Reset drops any in-flight read: WAIT is left and no response is produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data0_q <= '0;
         rsp_data1_q <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         pop2_q      <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data0_q <= rsp_data0_d;
         rsp_data1_q <= rsp_data1_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         pop2_q      <= pop2_d;
      end
   end

   assign sp        = sp_q;
   assign full      = (sp_q == SP_FULL);
   assign empty     = (sp_q == '0);
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_data0 = rsp_data0_q;
   assign rsp_data1 = rsp_data1_q;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PEEK = 2'b10;
   localparam logic [1:0] OP_POP2 = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [31:0]   cmd_data = '0;
   logic [AW-1:0] cmd_off = '0;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_data0, rsp_data1;
   logic [AW:0]   sp;
   logic          full, empty, overflow, underflow;
   logic [31:0]   ram_addr_a, ram_datain_a, ram_addr_b;
   logic          ram_wr_a;
   logic [31:0]   ram_data_a = '0, ram_data_b = '0;

   stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_off(cmd_off),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
      .sp(sp), .full(full), .empty(empty),
      .overflow(overflow), .underflow(underflow),
      .ram_addr_a(ram_addr_a), .ram_datain_a(ram_datain_a), .ram_wr_a(ram_wr_a),
      .ram_addr_b(ram_addr_b), .ram_data_a(ram_data_a), .ram_data_b(ram_data_b)
   );

   always #5 clk = ~clk;

   // Synchronous two-port RAM with registered read data.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_a) mem[ram_addr_a[AW-1:0]] <= ram_datain_a;
      ram_data_a <= mem[ram_addr_a[AW-1:0]];
      ram_data_b <= mem[ram_addr_b[AW-1:0]];
   end

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   typedef struct {
      logic        err;
      logic [31:0] d0;
      logic [31:0] d1;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mstk[$];
   logic        ovf_m = 1'b0, unf_m = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Response scoreboard: every response must match the oldest expectation
   // and appear exactly in its due cycle.
   initial forever begin
      @(negedge clk);
      if (rst_n && sbq.size() > 0 && sbq[0].due < cyc) begin
         vec_cnt++; err_cnt++;
         $display("FAIL rsp_missing: no response seen, required one in cycle %0d", sbq[0].due);
         void'(sbq.pop_front());
      end
      if (rsp_valid) begin
         vec_cnt++;
         if (sbq.size() == 0) begin
            err_cnt++;
            $display("FAIL rsp_unexpected: got err=%0b d0=%h d1=%h, required no response",
                     rsp_err, rsp_data0, rsp_data1);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if ({rsp_err, rsp_data0, rsp_data1} !== {e.err, e.d0, e.d1} || cyc != e.due) begin
               err_cnt++;
               $display("FAIL rsp_data: got err=%0b d0=%h d1=%h cyc=%0d, required err=%0b d0=%h d1=%h cyc=%0d",
                        rsp_err, rsp_data0, rsp_data1, cyc, e.err, e.d0, e.d1, e.due);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one command (called right after a negedge); checks RAM drive before
   // the accept edge and sp/flags/ready after it.
   task automatic issue(input logic [1:0] op, input logic [31:0] data, input logic [AW-1:0] off);
      int          n, sp_m, offi;
      logic        e, rd;
      logic [31:0] d0, d1, ea, eb, edin;
      logic        ewr;
      logic [AW:0] esp;
      exp_t        x;
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_off = off;
      n = 0;
      #1;
      while (!cmd_ready && n < 8) begin
         @(negedge clk); #1; n++;
      end
      vec_cnt++;
      if (!cmd_ready) begin
         err_cnt++;
         $display("FAIL cmd_ready_timeout: got cmd_ready=0, required 1 within 8 cycles");
         cmd_valid = 1'b0;
         return;
      end
      sp_m = mstk.size(); offi = int'(off);
      e = 1'b0; rd = 1'b0; d0 = '0; d1 = '0; ea = '0; eb = '0; edin = '0; ewr = 1'b0;
      case (op)
         OP_PUSH: begin
            e = (sp_m == DEPTH);
            if (!e) begin ewr = 1'b1; ea = 32'(sp_m); edin = data; d0 = data; end
         end
         OP_POP: begin
            e = (sp_m == 0);
            if (!e) begin rd = 1'b1; ea = 32'(sp_m - 1); d0 = mstk[sp_m-1]; end
         end
         OP_PEEK: begin
            e = (offi >= sp_m);
            if (!e) begin rd = 1'b1; ea = 32'(sp_m - 1 - offi); d0 = mstk[sp_m-1-offi]; end
         end
         default: begin
            e = (sp_m < 2);
            if (!e) begin
               rd = 1'b1; ea = 32'(sp_m - 1); eb = 32'(sp_m - 2);
               d0 = mstk[sp_m-1]; d1 = mstk[sp_m-2];
            end
         end
      endcase
      vec_cnt++;
      if ({ram_wr_a, ram_addr_a, ram_datain_a} !== {ewr, ea, edin} ||
          (op == OP_POP2 && ram_addr_b !== eb)) begin
         err_cnt++;
         $display("FAIL ram_drive op=%0d: got wr=%0b a=%h din=%h b=%h, required wr=%0b a=%h din=%h b=%h",
                  op, ram_wr_a, ram_addr_a, ram_datain_a, ram_addr_b, ewr, ea, edin, eb);
      end
      x.err = e; x.d0 = d0; x.d1 = d1; x.due = cyc + (rd ? 2 : 1);
      sbq.push_back(x);
      if (e) begin
         if (op == OP_PUSH) ovf_m = 1'b1; else unf_m = 1'b1;
      end else begin
         case (op)
            OP_PUSH: mstk.push_back(data);
            OP_POP:  void'(mstk.pop_back());
            OP_POP2: begin void'(mstk.pop_back()); void'(mstk.pop_back()); end
            default: ;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      esp = (AW+1)'(mstk.size());
      vec_cnt++;
      if ({sp, full, empty, overflow, underflow} !==
          {esp, esp == DEPTH[AW:0], esp == '0, ovf_m, unf_m}) begin
         err_cnt++;
         $display("FAIL sp_flags op=%0d: got sp=%0d f=%0b e=%0b ovf=%0b unf=%0b, required sp=%0d ovf=%0b unf=%0b",
                  op, sp, full, empty, overflow, underflow, esp, ovf_m, unf_m);
      end
      if (rd) begin
         vec_cnt++;
         if (cmd_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL ready_in_wait: got cmd_ready=%0b, required 0", cmd_ready);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; cmd_valid = 1'b0; clear = 1'b0;
      sbq.delete(); mstk.delete(); ovf_m = 1'b0; unf_m = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vec_cnt++;
      if ({sp, empty, full, cmd_ready, rsp_valid, rsp_err, overflow, underflow, ram_wr_a} !==
          {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_ctrl: got sp=%0d e=%0b f=%0b rdy=%0b rv=%0b re=%0b ovf=%0b unf=%0b wr=%0b, required 0 1 0 1 0 0 0 0 0",
                  sp, empty, full, cmd_ready, rsp_valid, rsp_err, overflow, underflow, ram_wr_a);
      end
      vec_cnt++;
      if ({rsp_data0, rsp_data1} !== 64'h0) begin
         err_cnt++;
         $display("FAIL reset_data: got d0=%h d1=%h, required 0 0", rsp_data0, rsp_data1);
      end
      @(negedge clk);
   endtask

   task automatic test_push_back_to_back();
      issue(OP_PUSH, 32'h11, '0);
      issue(OP_PUSH, 32'h22, '0);
      issue(OP_PUSH, 32'h33, '0);
   endtask

   task automatic test_pop2();
      issue(OP_POP2, '0, '0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) issue(OP_PUSH, 32'hA000 + 32'(i), '0);
      issue(OP_PUSH, 32'hDEAD, '0);
      issue(OP_POP2, '0, '0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_underflow();
      do_reset();
      issue(OP_POP, '0, '0);
      issue(OP_PUSH, 32'h5A5A, '0);
      issue(OP_POP2, '0, '0);
      issue(OP_PEEK, '0, 3'd1);
   endtask

   task automatic test_peek();
      do_reset();
      issue(OP_PUSH, 32'hA, '0);
      issue(OP_PUSH, 32'hB, '0);
      issue(OP_PUSH, 32'hC, '0);
      issue(OP_PEEK, '0, 3'd1);
      issue(OP_PEEK, '0, 3'd3);
      issue(OP_PEEK, '0, 3'd0);
      issue(OP_POP, '0, '0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_clear();
      logic sticky_unf;
      do_reset();
      issue(OP_POP, '0, '0);          // sets underflow
      issue(OP_PUSH, 32'h77, '0);
      issue(OP_PUSH, 32'h88, '0);
      issue(OP_POP, '0, '0);          // now in WAIT
      clear = 1'b1;
      @(posedge clk);
      mstk.delete();
      @(negedge clk);
      clear = 1'b0;
      sticky_unf = unf_m;
      vec_cnt++;
      if ({sp, underflow} !== {4'd0, sticky_unf}) begin
         err_cnt++;
         $display("FAIL clear_in_wait: got sp=%0d unf=%0b, required sp=0 unf=%0b", sp, underflow, sticky_unf);
      end
      // clear in IDLE blocks an offered command entirely
      issue(OP_PUSH, 32'h99, '0);
      cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 32'hBAD; clear = 1'b1;
      #1;
      vec_cnt++;
      if ({cmd_ready, ram_wr_a} !== 2'b00) begin
         err_cnt++;
         $display("FAIL clear_blocks_cmd: got rdy=%0b wr=%0b, required 0 0", cmd_ready, ram_wr_a);
      end
      @(posedge clk);
      mstk.delete();
      @(negedge clk);
      cmd_valid = 1'b0; clear = 1'b0;
      vec_cnt++;
      if (sp !== 4'd0) begin
         err_cnt++;
         $display("FAIL clear_idle_sp: got sp=%0d, required 0", sp);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      int seen;
      do_reset();
      issue(OP_PUSH, 32'h1234, '0);
      issue(OP_POP, '0, '0);          // now in WAIT
      rst_n = 1'b0;
      sbq.delete(); mstk.delete();
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 1) rst_n = 1'b1;
         if (rsp_valid) seen++;
      end
      #1;
      vec_cnt++;
      if ({seen == 0, sp, cmd_ready} !== {1'b1, 4'd0, 1'b1}) begin
         err_cnt++;
         $display("FAIL reset_in_wait: got responses=%0d sp=%0d rdy=%0b, required 0 0 1", seen, sp, cmd_ready);
      end
      issue(OP_PUSH, 32'h4321, '0);
      issue(OP_POP, '0, '0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_push_back_to_back();
      test_pop2();
      test_overflow();
      test_underflow();
      test_peek();
      test_clear();
      test_reset_in_wait();
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (sbq.size() != 0) begin
         err_cnt++;
         $display("FAIL rsp_outstanding: got %0d unanswered commands, required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
